// File: rtl/open_list_issue_ctrl.sv
// Issue front-end for the systolic min-first open list: arbitrates push/pop requests,
// merges them into replace commands, and paces queue commands by ISSUE_GAP cycles.
module open_list_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned ISSUE_GAP  = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               i_push_valid,
  input  logic [DATA_WIDTH-1:0]              i_push_data,
  output logic                               o_push_ready,
  input  logic                               i_pop_valid,
  output logic                               o_pop_ready,
  output logic                               o_res_valid,
  output logic [DATA_WIDTH-1:0]              o_res_data,
  output logic                               o_q_wrt,
  output logic                               o_q_read,
  output logic [DATA_WIDTH-1:0]              o_q_node_f,
  input  logic                               i_q_full,
  input  logic                               i_q_empty,
  input  logic [DATA_WIDTH-1:0]              i_q_node_f,
  output logic [$clog2(CAPACITY+1)-1:0]      o_count,
  output logic                               o_sync_err
);

  localparam int unsigned CntW = $clog2(CAPACITY + 1);
  localparam logic [CntW-1:0] CapCnt = CntW'(CAPACITY);
  localparam logic [3:0] GapInit = 4'(ISSUE_GAP - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [3:0]            gap_q, gap_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  q_wrt_q, q_wrt_d;
  logic                  q_read_q, q_read_d;
  logic [DATA_WIDTH-1:0] node_f_q, node_f_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  sync_err_q, sync_err_d;

  logic is_idle, cnt_zero, cnt_full;
  logic push_ready, pop_ready, push_acc, pop_acc;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (push_acc || pop_acc) begin
          state_d = StBusy;
          gap_d   = GapInit;
        end
      end
      StBusy: begin
        if (gap_q <= 4'd1) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = '0;
      end
    endcase
  end

  // Output logic: readies only in IDLE; a full queue still accepts a push merged with a pop
  always_comb begin
    is_idle    = (state_q == StIdle);
    cnt_zero   = (count_q == '0);
    cnt_full   = (count_q == CapCnt);
    push_ready = is_idle && (!cnt_full || (i_pop_valid && !cnt_zero));
    pop_ready  = is_idle && !cnt_zero;
    push_acc   = i_push_valid && push_ready;
    pop_acc    = i_pop_valid && pop_ready;
  end

  assign o_push_ready = push_ready;
  assign o_pop_ready  = pop_ready;

  // Command, result and occupancy datapath
  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CntW'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CntW'(1);
    end
    q_wrt_d     = push_acc;
    q_read_d    = pop_acc;
    node_f_d    = push_acc ? i_push_data : node_f_q;
    res_valid_d = pop_acc;
    res_data_d  = pop_acc ? i_q_node_f : res_data_q;
    // Flags are only trusted once the array has settled, i.e. in IDLE
    sync_err_d  = sync_err_q ||
                  (is_idle && ((cnt_full != i_q_full) || (cnt_zero != i_q_empty)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q     <= '0;
      q_wrt_q     <= 1'b0;
      q_read_q    <= 1'b0;
      node_f_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      q_wrt_q     <= q_wrt_d;
      q_read_q    <= q_read_d;
      node_f_q    <= node_f_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign o_count     = count_q;
  assign o_q_wrt     = q_wrt_q;
  assign o_q_read    = q_read_q;
  assign o_q_node_f  = node_f_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_sync_err  = sync_err_q;

endmodule

// File: tb/tb_open_list_issue_ctrl.sv
// Directed bench for open_list_issue_ctrl with a sorted-queue stand-in for the systolic array.
module tb_open_list_issue_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned CAP = 8;
  localparam int unsigned GAP = 4;
  localparam int unsigned CW = $clog2(CAP + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          i_push_valid = 1'b0;
  logic [DW-1:0] i_push_data = '0;
  logic          o_push_ready;
  logic          i_pop_valid = 1'b0;
  logic          o_pop_ready;
  logic          o_res_valid;
  logic [DW-1:0] o_res_data;
  logic          o_q_wrt;
  logic          o_q_read;
  logic [DW-1:0] o_q_node_f;
  logic          i_q_full;
  logic          i_q_empty;
  logic [DW-1:0] i_q_node_f;
  logic [CW-1:0] o_count;
  logic          o_sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  open_list_issue_ctrl #(
    .DATA_WIDTH(DW),
    .CAPACITY  (CAP),
    .ISSUE_GAP (GAP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_push_valid(i_push_valid),
    .i_push_data (i_push_data),
    .o_push_ready(o_push_ready),
    .i_pop_valid (i_pop_valid),
    .o_pop_ready (o_pop_ready),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .o_q_wrt     (o_q_wrt),
    .o_q_read    (o_q_read),
    .o_q_node_f  (o_q_node_f),
    .i_q_full    (i_q_full),
    .i_q_empty   (i_q_empty),
    .i_q_node_f  (i_q_node_f),
    .o_count     (o_count),
    .o_sync_err  (o_sync_err)
  );

  always #5 CLK = ~CLK;

  // Downstream queue stand-in: sorted ascending, head is the minimum
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] mdl_min = '0;
  int            mdl_n = 0;
  logic          force_nonempty = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      mdl_q.delete();
    end else begin
      if (o_q_read && mdl_q.size() > 0) void'(mdl_q.pop_front());
      if (o_q_wrt) begin
        mdl_q.push_back(o_q_node_f);
        mdl_q.sort();
      end
    end
    mdl_n   <= mdl_q.size();
    mdl_min <= (mdl_q.size() > 0) ? mdl_q[0] : '0;
  end

  assign i_q_node_f = mdl_min;
  assign i_q_full   = (mdl_n == int'(CAP));
  assign i_q_empty  = force_nonempty ? 1'b0 : (mdl_n == 0);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic          qv;
    logic          e_pr;
    logic          e_qr;
    logic [DW-1:0] e_rd;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic apply(input vec_t v);
    logic acc_push, acc_pop;
    @(negedge CLK);
    i_push_valid = v.pv;
    i_push_data  = v.pd;
    i_pop_valid  = v.qv;
    #1;
    if (v.pv) chk("push_ready", {31'd0, o_push_ready}, {31'd0, v.e_pr});
    if (v.qv) chk("pop_ready", {31'd0, o_pop_ready}, {31'd0, v.e_qr});
    acc_push = v.pv & v.e_pr;
    acc_pop  = v.qv & v.e_qr;
    @(posedge CLK);
    #1;
    i_push_valid = 1'b0;
    i_pop_valid  = 1'b0;
    chk("q_wrt", {31'd0, o_q_wrt}, {31'd0, acc_push});
    chk("q_read", {31'd0, o_q_read}, {31'd0, acc_pop});
    chk("res_valid", {31'd0, o_res_valid}, {31'd0, acc_pop});
    if (acc_push) chk("q_node_f", o_q_node_f, v.pd);
    if (acc_pop) chk("res_data", o_res_data, v.e_rd);
    chk("count", {{(DW-CW){1'b0}}, o_count}, {{(DW-CW){1'b0}}, v.e_cnt});
    if (acc_push || acc_pop) begin
      chk("busy_push_ready", {31'd0, o_push_ready}, 32'd0);
      chk("busy_pop_ready", {31'd0, o_pop_ready}, 32'd0);
      for (int k = 0; k < int'(GAP) - 2; k++) begin
        @(posedge CLK);
        #1;
        chk("busy_push_ready", {31'd0, o_push_ready}, 32'd0);
        chk("pulse_cmd", {30'd0, o_q_wrt, o_q_read}, 32'd0);
        chk("pulse_res", {31'd0, o_res_valid}, 32'd0);
        if (acc_push) chk("node_f_hold", o_q_node_f, v.pd);
        if (acc_pop) chk("res_data_hold", o_res_data, v.e_rd);
      end
      @(posedge CLK);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(vecs[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'd500, 1'b0, 1'b1, 1'b0, 32'd0,   4'd1};
    vecs[1]  = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd500, 4'd0};
    vecs[2]  = '{1'b1, 32'd9,   1'b0, 1'b1, 1'b0, 32'd0,   4'd1};
    vecs[3]  = '{1'b1, 32'd3,   1'b0, 1'b1, 1'b0, 32'd0,   4'd2};
    vecs[4]  = '{1'b1, 32'd7,   1'b0, 1'b1, 1'b0, 32'd0,   4'd3};
    vecs[5]  = '{1'b1, 32'd1,   1'b0, 1'b1, 1'b0, 32'd0,   4'd4};
    vecs[6]  = '{1'b1, 32'd8,   1'b0, 1'b1, 1'b0, 32'd0,   4'd5};
    vecs[7]  = '{1'b1, 32'd2,   1'b0, 1'b1, 1'b0, 32'd0,   4'd6};
    vecs[8]  = '{1'b1, 32'd6,   1'b0, 1'b1, 1'b0, 32'd0,   4'd7};
    vecs[9]  = '{1'b1, 32'd4,   1'b0, 1'b1, 1'b0, 32'd0,   4'd8};
    // Replace at full, then replace with min 3
    vecs[10] = '{1'b1, 32'd5,   1'b1, 1'b1, 1'b1, 32'd1,   4'd8};
    vecs[11] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd2,   4'd7};
    vecs[12] = '{1'b1, 32'd10,  1'b1, 1'b1, 1'b1, 32'd3,   4'd7};
    vecs[13] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd4,   4'd6};
    vecs[14] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd5,   4'd5};
    vecs[15] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd6,   4'd4};
    vecs[16] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd7,   4'd3};
    vecs[17] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd8,   4'd2};
    vecs[18] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd9,   4'd1};
    vecs[19] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd10,  4'd0};
    // Push and pop on an empty queue: push only
    vecs[20] = '{1'b1, 32'd42,  1'b1, 1'b1, 1'b0, 32'd0,   4'd1};
    vecs[21] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd42,  4'd0};

    // Reset state
    #1;
    chk("rst_count", {28'd0, o_count}, 32'd0);
    chk("rst_cmds", {29'd0, o_q_wrt, o_q_read, o_res_valid}, 32'd0);
    chk("rst_sync_err", {31'd0, o_sync_err}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    run_range(0, 9);

    // Push alone at capacity is held off
    @(negedge CLK);
    i_push_valid = 1'b1;
    i_push_data  = 32'd99;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("full_push_ready", {31'd0, o_push_ready}, 32'd0);
      @(posedge CLK);
      #1;
      chk("full_no_wrt", {31'd0, o_q_wrt}, 32'd0);
      @(negedge CLK);
    end
    i_push_valid = 1'b0;
    chk("full_count", {28'd0, o_count}, 32'd8);

    run_range(10, 19);

    // Pop alone on empty is never accepted
    @(negedge CLK);
    i_pop_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("empty_pop_ready", {31'd0, o_pop_ready}, 32'd0);
      @(posedge CLK);
      #1;
      chk("empty_no_read", {31'd0, o_q_read}, 32'd0);
      @(negedge CLK);
    end
    i_pop_valid = 1'b0;

    run_range(20, 21);
    chk("no_sync_err", {31'd0, o_sync_err}, 32'd0);

    // Reset while BUSY after a pop handshake
    apply('{1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 32'd0, 4'd1});
    @(negedge CLK);
    i_pop_valid = 1'b1;
    #1;
    chk("pre_rst_pop_ready", {31'd0, o_pop_ready}, 32'd1);
    @(posedge CLK);
    #1;
    i_pop_valid = 1'b0;
    chk("pre_rst_read", {31'd0, o_q_read}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_busy_cmds", {29'd0, o_q_wrt, o_q_read, o_res_valid}, 32'd0);
    chk("rst_busy_count", {28'd0, o_count}, 32'd0);
    chk("rst_busy_res_data", o_res_data, 32'd0);
    chk("rst_busy_node_f", o_q_node_f, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      #1;
      chk("post_rst_no_read", {31'd0, o_q_read}, 32'd0);
    end

    // Flag disagreement in IDLE latches the sticky error
    @(negedge CLK);
    force_nonempty = 1'b1;
    @(posedge CLK);
    #1;
    chk("sync_err_set", {31'd0, o_sync_err}, 32'd1);
    @(negedge CLK);
    force_nonempty = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("sync_err_sticky", {31'd0, o_sync_err}, 32'd1);
    RST = 1'b1;
    #1;
    chk("sync_err_rst", {31'd0, o_sync_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/open_list_issue_ctrl.md
Name: open_list_issue_ctrl

Overview:
- Upstream front-end of the systolic open-list priority queue (min-first).
- Accepts independent push and pop requests from the search/expansion logic over valid/ready handshakes.
- Merges simultaneous push+pop into a single replace, and gates requests on an internal occupancy count.
- Spaces queue commands so the systolic array settles between them, and returns each popped minimum on a one-cycle result strobe.

Parameters:
- DATA_WIDTH, 32, width of node f value.
- CAPACITY, 8, number of entries the downstream queue holds (2 x its QUEUE_SIZE).
- ISSUE_GAP, 4, minimum cycles between consecutive queue commands (command cycle included); legal range 2..15.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- i_push_valid  in  1  push request.
- i_push_data  in  DATA_WIDTH  node f to insert.
- o_push_ready  out  1  push accepted this cycle when high with i_push_valid.
- i_pop_valid  in  1  pop request.
- o_pop_ready  out  1  pop accepted this cycle when high with i_pop_valid.
- o_res_valid  out  1  one-cycle strobe: popped value on o_res_data.
- o_res_data  out  DATA_WIDTH  popped minimum.
- o_q_wrt  out  1  queue enqueue command.
- o_q_read  out  1  queue dequeue command.
- o_q_node_f  out  DATA_WIDTH  queue insert data.
- i_q_full  in  1  queue full flag.
- i_q_empty  in  1  queue empty flag.
- i_q_node_f  in  DATA_WIDTH  queue current minimum.
- o_count  out  $clog2(CAPACITY+1)  tracked occupancy.
- o_sync_err  out  1  sticky: tracked count disagrees with queue flags.

Behaviour:
- Reset (async, RST high): state IDLE, gap counter 0, o_count 0, all command/result outputs 0, o_sync_err 0. Reset during BUSY drops any pending command; no command is issued after RST deasserts.
- States:
  - IDLE: readies may assert.
  - BUSY: readies held 0; gap counter runs.
- Decision in IDLE (combinational readies; valids must not depend on readies):
  - push and pop valid, count>0 -> REPLACE; both readies 1; count unchanged. Allowed at count==CAPACITY.
  - push and pop valid, count==0 -> PUSH only; o_pop_ready 0.
  - push only, count<CAPACITY -> PUSH; count+1.
  - push only, count==CAPACITY -> no ready; stay IDLE.
  - pop only, count>0 -> POP; count-1.
  - pop only, count==0 -> no ready.
- Handshake cycle T (any accepted op):
  - registered at edge T: o_q_node_f<=i_push_data (PUSH/REPLACE); o_q_wrt<=push accepted; o_q_read<=pop accepted; o_count updated.
  - For POP/REPLACE, o_res_data<=i_q_node_f sampled at T (queue settled) and o_res_valid<=1.
  - State->BUSY, gap counter<=ISSUE_GAP-1.
- Cycle T+1: o_q_wrt/o_q_read/o_res_valid high exactly one cycle, then 0. o_q_node_f and o_res_data hold their last values.
- BUSY: counter decrements each cycle; at 1 -> IDLE. Next handshake earliest at T+ISSUE_GAP.
- Sync check, in IDLE only: if (count==CAPACITY)!=i_q_full or (count==0)!=i_q_empty, set o_sync_err; it clears only on reset. Not checked in BUSY.
- Count never wraps: saturation is guaranteed by the gating above; no arithmetic overflow path exists.

Test Plan:
- Reset, then push 500: o_push_ready=1 at T; o_q_wrt=1, o_q_node_f=500 at T+1 only; o_count=1; o_push_ready=0 for cycles T+1..T+3; ready again at T+4.
- Fill with 9,3,7,1,8,2,6,4 (ISSUE_GAP=4): o_count=8. Further push alone -> o_push_ready stays 0 for 20 cycles; no o_q_wrt.
- Queue min=3, simultaneous push 10 / pop: single cycle with o_q_wrt=o_q_read=1, o_q_node_f=10; o_res_valid=1, o_res_data=3; o_count unchanged.
- Empty, pop only: o_pop_ready=0 indefinitely. Add push 42 in the same cycle -> PUSH only, o_q_read=0, o_count=1; pop accepted 4 cycles later, returns 42, o_count=0.
- Assert RST during BUSY after a pop handshake: all outputs 0 immediately; o_count=0; no o_q_read pulse after release.
- Hold i_q_empty=0 while o_count=0 in IDLE: o_sync_err=1 and stays 1 after i_q_empty returns to 1; cleared only by RST.
